// File: rtl/issue_reorder_buffer_pkg.sv
// Shared types for the issue reorder buffer.
// Provides a trimmed-down scoreboard entry (fields the buffer actually looks at
// plus the PC for identification), the buffered entry wrapper and the
// functional-unit classification helpers used for bypass decisions.
package issue_reorder_buffer_pkg;

    typedef enum logic [3:0] {
        NONE      = 4'd0,
        LOAD      = 4'd1,
        STORE     = 4'd2,
        ALU       = 4'd3,
        CTRL_FLOW = 4'd4,
        MULT      = 4'd5,
        CSR       = 4'd6,
        FPU       = 4'd7
    } fu_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } scoreboard_entry_t;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } reorder_entry_t;

    // Loads and stores are the ops that wait on the LSU.
    function automatic logic is_mem_op(input fu_t fu);
        return (fu == LOAD) || (fu == STORE);
    endfunction

    // Only plain compute ops may overtake a stalled memory head; branches and
    // CSR accesses have side effects that must stay in program order.
    function automatic logic is_bypassable(input fu_t fu);
        return !((fu == LOAD) || (fu == STORE) || (fu == CTRL_FLOW) || (fu == CSR));
    endfunction

endpackage

// File: rtl/issue_reorder_buffer_if.sv
// Instruction handshake bundle: an entry with its control-flow flag, a valid
// and an ack travelling back. The producer side uses the master modport, the
// consumer side uses the slave modport.
interface issue_reorder_buffer_if;
    import issue_reorder_buffer_pkg::*;

    scoreboard_entry_t issue_entry;
    logic              issue_entry_valid;
    logic              is_ctrl_flow;
    logic              issue_instr_ack;

    modport master (
        output issue_entry,
        output issue_entry_valid,
        output is_ctrl_flow,
        input  issue_instr_ack
    );

    modport slave (
        input  issue_entry,
        input  issue_entry_valid,
        input  is_ctrl_flow,
        output issue_instr_ack
    );

endinterface

// File: rtl/issue_reorder_buffer_hazard.sv
// Pairwise register hazard detector for the issue reorder buffer.
// Flags any RAW, WAR or WAW overlap between a candidate and one older entry.
// Register indices are compared as raw 5-bit values, so integer and FP
// registers alias and x0 is treated like any other register.
module reorder_hazard_check
    import issue_reorder_buffer_pkg::*;
(
    input  reorder_entry_t cand_i,
    input  reorder_entry_t older_i,
    output logic           conflict_o
);

    logic unusedBits;

    // Conflict if the candidate reads what the older writes, writes what the
    // older reads, or writes the same destination.
    always_comb begin
        conflict_o = (cand_i.sbe.rs1 == older_i.sbe.rd)  |
                     (cand_i.sbe.rs2 == older_i.sbe.rd)  |
                     (cand_i.sbe.rd  == older_i.sbe.rs1) |
                     (cand_i.sbe.rd  == older_i.sbe.rs2) |
                     (cand_i.sbe.rd  == older_i.sbe.rd);
    end

    assign unusedBits = ^{cand_i.sbe.pc, cand_i.sbe.fu, cand_i.is_ctrl_flow,
                          older_i.sbe.pc, older_i.sbe.fu, older_i.is_ctrl_flow};

endmodule

// File: rtl/issue_reorder_buffer.sv
// Issue reorder buffer: in-order instruction queue between decode and issue
// that lets independent compute ops slip past a load/store head while the LSU
// is stalled, with a per-head limit on how many may overtake it.
// Optional build macro REORDER_BYPASS_STATS_EN adds a bypass pop counter and
// a bypass-active indicator.
module issue_reorder_buffer
    import issue_reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_BYPASS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  debug_req_i,
    issue_reorder_buffer_if.slave  decode_i,
    issue_reorder_buffer_if.master issue_o,
    input  logic                  lsu_ready_i
`ifdef REORDER_BYPASS_STATS_EN
    ,
    output logic [31:0]           bypass_count_o,
    output logic [0:0]            bypass_active_o
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_BYPASS + 1);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned IW    = $clog2(DEPTH);

    reorder_entry_t   slots_q [DEPTH];
    reorder_entry_t   slots_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CNT_W-1:0] bypassCnt_q;
    logic [CNT_W-1:0] bypassCnt_d;

    logic             conflict [DEPTH][DEPTH];
    logic [DEPTH-1:0] eligible;
    logic             bypass;
    logic [IW-1:0]    selIdx;
    reorder_entry_t   selEntry;
    reorder_entry_t   newEntry;
    logic             ackOut;
    logic             validOut;
    logic             push;
    logic             pop;
    logic [CW-1:0]    remain;

    // One hazard checker per (younger k, older j) pair; other cells tie low.
    for (genvar k = 0; k < DEPTH; k++) begin : g_cand
        for (genvar j = 0; j < DEPTH; j++) begin : g_older
            if (j < k) begin : g_pair
                reorder_hazard_check u_hazard (
                    .cand_i     (slots_q[k]),
                    .older_i    (slots_q[j]),
                    .conflict_o (conflict[k][j])
                );
            end else begin : g_none
                assign conflict[k][j] = 1'b0;
            end
        end
    end

    // A slot may overtake the head if it is occupied, a plain compute op and
    // free of hazards against every older slot.
    always_comb begin
        eligible = '0;
        for (int k = 1; k < DEPTH; k++) begin
            eligible[k] = (k < int'(count_q)) && is_bypassable(slots_q[k].sbe.fu);
            for (int j = 0; j < k; j++) begin
                if (conflict[k][j]) begin
                    eligible[k] = 1'b0;
                end
            end
        end
    end

    // Pick the lowest eligible slot when the memory head is stuck, else the head.
    always_comb begin
        selIdx = '0;
        bypass = is_mem_op(slots_q[0].sbe.fu) && !lsu_ready_i && !debug_req_i &&
                 (bypassCnt_q < CNT_W'(MAX_BYPASS)) && (|eligible);
        if (bypass) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (eligible[k]) begin
                    selIdx = IW'(k);
                end
            end
        end
    end

    assign selEntry              = slots_q[selIdx];
    assign validOut              = (count_q != '0) && !flush_i;
    assign ackOut                = (count_q != CW'(DEPTH));
    assign newEntry.sbe          = decode_i.issue_entry;
    assign newEntry.is_ctrl_flow = decode_i.is_ctrl_flow;
    assign push                  = decode_i.issue_entry_valid && ackOut && !flush_i;
    assign pop                   = validOut && issue_o.issue_instr_ack;

    assign decode_i.issue_instr_ack  = ackOut;
    assign issue_o.issue_entry       = selEntry.sbe;
    assign issue_o.is_ctrl_flow      = selEntry.is_ctrl_flow;
    assign issue_o.issue_entry_valid = validOut;

    // Next state: remove the popped slot by shifting younger ones down, then
    // append any accepted entry behind the survivors.
    always_comb begin
        slots_d     = slots_q;
        count_d     = count_q;
        bypassCnt_d = bypassCnt_q;
        remain      = count_q - CW'(pop);
        if (flush_i) begin
            count_d     = '0;
            bypassCnt_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (IW'(i) >= selIdx) begin
                        slots_d[i] = slots_q[i + 1];
                    end
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == remain) begin
                        slots_d[i] = newEntry;
                    end
                end
            end
            count_d = remain + CW'(push);
            if (pop) begin
                if (selIdx != '0) begin
                    bypassCnt_d = bypassCnt_q + CNT_W'(1);
                end else if (!debug_req_i) begin
                    bypassCnt_d = '0;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            count_q     <= '0;
            bypassCnt_q <= '0;
        end else begin
            slots_q     <= slots_d;
            count_q     <= count_d;
            bypassCnt_q <= bypassCnt_d;
        end
    end

`ifdef REORDER_BYPASS_STATS_EN
    logic [31:0] bypassCount_q;

    // Free-running count of bypass pops; survives flushes, wraps at 2^32.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bypassCount_q <= '0;
        end else if (pop && (selIdx != '0)) begin
            bypassCount_q <= bypassCount_q + 32'd1;
        end
    end

    assign bypass_count_o  = bypassCount_q;
    assign bypass_active_o = bypass;
`endif

endmodule
